// File: rtl/uart_rx.sv
// Purpose : oversampling UART receiver (8N1, LSB first) feeding a show-ahead receive FIFO read over MMIO.
// Latency : byte visible on rd_data/rx_valid on the edge that samples the stop bit (~2+1+(CLKS_PER_BIT-1)/2+9*CLKS_PER_BIT after the rx falling edge).
// Backpr. : none on the serial side; a byte arriving into a full FIFO (with no same-cycle pop) is dropped and sets sticky overrun.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous, active-low reset
//   rx        serial input, idles high, asynchronous to clk
//   rd_en     pop the FIFO head (ignored while empty)
//   clr_err   one-cycle pulse clearing overrun and frame_err (a same-cycle error event wins)
//   rd_data   FIFO head, 0x00 while empty
//   rx_valid  FIFO not empty
//   rx_busy   receiver FSM not idle
//   overrun   sticky: byte dropped because the FIFO was full
//   frame_err sticky: stop bit sampled low, or parity mismatch
//
// Optional feature: define UART_RX_PARITY_EN for 8E1 frames (PARITY state between DATA and STOP).

module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       overrun,
  output logic       frame_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  // ---------------------------------------------------------------
  // Input synchroniser; rxs_prev_q feeds the falling-edge detector.
  // All three reset high so a line that is already low when reset
  // releases is not mistaken for a start bit until it goes high first.
  // ---------------------------------------------------------------
  logic rx_meta_q, rxs_q, rxs_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // ---------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push;
  logic          frame_set;
`ifdef UART_RX_PARITY_EN
  // Remembers a parity failure so STOP still runs but drops the byte.
  logic          par_bad_q, par_bad_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif

    case (state_q)
      IDLE: begin
        if (rxs_prev_q && !rxs_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == HALF_CNT) begin
          if (!rxs_q) begin
            // Still low at mid-bit: genuine start. Later samples land
            // one full bit apart, i.e. near each bit's centre.
            state_d   = DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = STOP;
          // Even parity: data bits plus parity bit must XOR to zero.
          if (^{shift_q, rxs_q}) begin
            frame_set = 1'b1;
            par_bad_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (rxs_q) begin
            // Leaving half a bit early lets a back-to-back start bit be seen.
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            push    = !par_bad_q;
`else
            push    = 1'b1;
`endif
          end else begin
            frame_set = 1'b1;
            state_d   = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_IDLE: begin
        // Hold off until the line returns high so a break is not a start bit.
        if (rxs_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign rx_busy = (state_q != IDLE);

  // ---------------------------------------------------------------
  // Show-ahead receive FIFO. Pointers carry an extra wrap bit so full
  // and empty are both just pointer comparisons.
  // ---------------------------------------------------------------
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  mem_d [FIFO_DEPTH];
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  logic        fifo_empty, fifo_full;
  logic        pop_ok, push_ok, ovr_set;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // still succeeds then; only an unaccompanied push when full is dropped.
  assign pop_ok  = rd_en && !fifo_empty;
  assign push_ok = push && (!fifo_full || pop_ok);
  assign ovr_set = push && fifo_full && !pop_ok;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop_ok};
    if (push_ok) begin
      mem_d[wr_ptr_q[PW-1:0]] = shift_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign rx_valid = !fifo_empty;
  assign rd_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[PW-1:0]];

  // ---------------------------------------------------------------
  // Sticky error flags: a new error in the clearing cycle wins.
  // ---------------------------------------------------------------
  logic overrun_q, overrun_d;
  logic frame_err_q, frame_err_d;

  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (clr_err) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    if (ovr_set) begin
      overrun_d = 1'b1;
    end
    if (frame_set) begin
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Memory-mapped UART receiver: the receive-side counterpart of the UART transmitter in DataMemory's MMIO region. It oversamples a serial line with a fixed clock-per-bit count and deserialises 8N1 frames, LSB first. Received bytes are buffered in a small show-ahead FIFO that DataMemory reads through MMIO. In loopback benches its `rx` input is driven directly by the transmitter's `uart_tx_wire`.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per serial bit; must be ≥ 4. Benches override it to 10.
- `FIFO_DEPTH`, 8, receive FIFO entries; must be a power of two, ≥ 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial input; idles high; asynchronous to `clk`.
- `rd_en`  in  1  pop request; pops the FIFO head when `rx_valid` is 1.
- `clr_err`  in  1  one-cycle pulse; clears `overrun` and `frame_err`.
- `rd_data`  out  8  FIFO head (show-ahead); holds 0x00 when the FIFO is empty.
- `rx_valid`  out  1  FIFO not empty.
- `rx_busy`  out  1  FSM is not in IDLE.
- `overrun`  out  1  sticky; a byte was dropped because the FIFO was full.
- `frame_err`  out  1  sticky; a stop bit was sampled low (or a parity mismatch, see Configuration).

## Operation
- `rx` passes through a 2-flop synchroniser. Both flops reset to 1. All following logic uses only the synchronised value `rxs`.
- FSM states: IDLE, START, DATA, STOP, and WAIT_IDLE (plus PARITY when `UART_RX_PARITY_EN` is defined).
  - IDLE: a 1→0 transition on `rxs` moves to START and clears the bit counter `cnt`.
  - START: on `cnt == (CLKS_PER_BIT-1)/2` (mid-bit), sample `rxs`.
    - 0: go to DATA, `cnt` = 0.
    - 1: false start; return to IDLE with no flags set.
  - DATA: every time `cnt` reaches `CLKS_PER_BIT-1`, sample a bit into the shift register, LSB first. After the 8th bit, go to STOP.
  - STOP: when `cnt` reaches `CLKS_PER_BIT-1`, sample the stop bit.
    - 1: push the byte, go to IDLE.
    - 0: set `frame_err`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rxs` == 1, then go to IDLE. This stops a break condition from being read as a start bit.
- FIFO: binary read/write pointers with one extra wrap bit. Full and empty are decided from pointer equality plus the wrap bit. Both pointers wrap modulo `FIFO_DEPTH`.
- Push when full: the byte is dropped and `overrun` is set. Existing contents are unchanged.
- Push and pop in the same cycle:
  - Both succeed in every case, including when full; `overrun` is not set.
  - When empty, the pop is ignored and the push succeeds.
- `rd_en` while empty: no effect.
- `clr_err` in the same cycle as a new error event: the error wins and the flag stays 1.
- Asserting `rst` mid-frame returns the block to its reset state immediately:
  - FSM goes to IDLE and the FIFO empties.
  - All flags clear and the partial byte is lost.
  - After release, a frame already in progress is not captured until `rxs` has been seen high in IDLE, which is the normal falling-edge detect.

## Timing
- Reset values: `rd_data` = 0x00, `rx_valid` = 0, `rx_busy` = 0, `overrun` = 0, `frame_err` = 0. Synchroniser flops = 1, FSM = IDLE, pointers = 0.
- Input latency: `rxs` lags `rx` by 2 cycles.
- Byte latency: the FIFO is written on the clock edge that samples the stop bit. `rx_valid` and `rd_data` update on that same edge.
- Pop: `rd_data` shows the next entry (or 0x00 if now empty) on the edge that consumes `rd_en`.
- Frame capture, falling edge of `rx` to `rx_valid` rising: 2 + 1 + (CLKS_PER_BIT-1)/2 + 9·CLKS_PER_BIT cycles, ±1. With the parity option, add CLKS_PER_BIT.
- Back-to-back frames: a start bit that begins immediately after the stop bit is accepted. The FSM re-enters IDLE half a bit before the end of the stop bit.

## Configuration
- `UART_RX_PARITY_EN` defined: frames are 8E1. A PARITY state is inserted between DATA and STOP and samples one bit at `CLKS_PER_BIT` spacing.
  - If the XOR of the 8 data bits and the parity bit is not 0: set `frame_err` and discard the byte. The STOP state still runs.
- `UART_RX_PARITY_EN` undefined: frames are 8N1. The PARITY state and its logic do not exist.

## Test plan
- Tests use `CLKS_PER_BIT` = 10.
- Send 0x41 → `rx_valid` rises within 2+1+4+90 ±1 cycles of the falling edge, `rd_data` = 0x41. After a `rd_en` pulse, `rx_valid` = 0 and `rd_data` = 0x00.
- Send 'A' (0x41) then 'B' (0x42) back to back with no idle gap → the FIFO holds 0x41 then 0x42, in order, and no flags are set.
- Drive `rx` low for 3 cycles, then high → no push, `rx_busy` returns to 0, and both flags stay 0.
- Send 0x55 with the stop bit forced to 0 and `rx` held low for 30 cycles → `frame_err` = 1 and the FIFO is empty. A following 0x5A is received correctly. After a `clr_err` pulse, `frame_err` = 0.
- Send 9 bytes 0x01–0x09 without popping → 8 entries 0x01–0x08 and `overrun` = 1. Repeat with a pop in the same cycle as the 9th push → `overrun` = 0, 0x01 is popped, and 0x09 sits at the tail.
- Assert `rst` during data bit 4 of 0x33, release it, then send 0xC3 → only 0xC3 is received and all flags stay 0. With `UART_RX_PARITY_EN` defined, 0xC3 sent with a wrong parity bit sets `frame_err`.
